// File: rtl/mem_pkg.sv
// mem_pkg: shared width codes, FSM states and helper functions for the memory access unit
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  function automatic logic is_err(input logic store, input logic [2:0] f3, input logic [1:0] off);
    return f3 == F3_B  ? 1'b0 :
           f3 == F3_H  ? off[0] :
           f3 == F3_W  ? |off :
           f3 == F3_BU ? store :
           f3 == F3_HU ? store | off[0] : 1'b1;
  endfunction
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    return f3 == F3_W ? 4'b1111 :
           f3 == F3_H ? 4'b0011 << off :
           f3 == F3_B ? 4'b0001 << off : 4'b0000;
  endfunction
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    return f3 == F3_W ? wdata : f3 == F3_H ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response handshake and data memory port
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half from a memory word and extends it per funct3
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select followed by sign/zero extension
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    data = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_BU ? {24'h0, b} :
           funct3 == F3_HU ? {16'h0, h} :
           funct3 == F3_W  ? rdata : '0;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit translating byte-addressed requests into word memory accesses
module mem_access_unit
  import mem_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mem_access_unit_if.slave bus
);
  state_t      state, state_n;
  logic        store_q, err_q, accept, req_err;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q, rdata_q, aligned;
  assign accept  = state == IDLE && bus.req_valid;
  assign req_err = is_err(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
  load_align u_align (.rdata(bus.mem_rdata), .off(off_q), .funct3(f3_q), .data(aligned));
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  // next-state: erroneous requests skip the memory entirely
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = !bus.req_valid ? IDLE : req_err ? DONE : ACCESS;
      ACCESS:  state_n = store_q ? DONE : WAIT;
      WAIT:    state_n = DONE;
      DONE:    state_n = bus.resp_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // request latch and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      store_q <= bus.req_store;
      err_q   <= req_err;
      f3_q    <= bus.req_funct3;
      off_q   <= bus.req_addr[1:0];
      word_q  <= bus.req_addr[31:2];
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (state == WAIT) begin
      rdata_q <= aligned;
    end else if (state == DONE && bus.resp_ready) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == DONE;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = (state == ACCESS || state == WAIT) ? {word_q, 2'b00} : '0;
  assign bus.mem_we     = (state == ACCESS && store_q) ? byte_en(f3_q, off_q) : '0;
  assign bus.mem_wdata  = (state == ACCESS && store_q) ? store_lanes(f3_q, wdata_q) : '0;
endmodule
